// File: rtl/window_3x3_gen_pkg.sv
// rtl/window_3x3_gen_pkg.sv - shared tap constants for the 3x3 window generator
package window_3x3_gen_pkg;
  localparam int WIN_TAPS = 9;
  // Tap index = slot position inside the packed window word; P00 occupies the MSBs.
  localparam int P00 = 8;
  localparam int P01 = 7;
  localparam int P02 = 6;
  localparam int P10 = 5;
  localparam int P11 = 4;
  localparam int P12 = 3;
  localparam int P20 = 2;
  localparam int P21 = 1;
  localparam int P22 = 0;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// rtl/window_3x3_gen_line_buffer.sv - one-line pixel store, 1 write + 1 synchronous read, no reset
module line_buffer #(
  parameter int DEPTH  = 400,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - sliding 3x3 neighbourhood builder over the downsampled pixel stream
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300,
  parameter int DATA_W = 8,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 9
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [DATA_W-1:0]            data,
  input  logic                         blanking,
  output logic                         win_valid,
  output logic [WIN_TAPS*DATA_W-1:0]   win,
  output logic [COL_W-1:0]             win_x,
  output logic [ROW_W-1:0]             win_y,
  output logic                         frame_done
);
  logic              accept;
  logic [COL_W-1:0]  col, s1_col;
  logic [ROW_W-1:0]  row, s1_row;
  logic              s1_valid;
  logic [DATA_W-1:0] data_d, lb0_q, lb1_q;
  logic [DATA_W-1:0] taps [WIN_TAPS];

  assign accept = valid && !blanking;

  // lb0 holds line row-1, lb1 holds line row-2; lb1 is fed from lb0's old value.
  line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) lb0 (
    .clock(clock), .we(s1_valid), .waddr(s1_col), .wdata(data_d),
    .re(accept), .raddr(col), .rdata(lb0_q)
  );

  line_buffer #(.DEPTH(WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) lb1 (
    .clock(clock), .we(s1_valid), .waddr(s1_col), .wdata(lb0_q),
    .re(accept), .raddr(col), .rdata(lb1_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      data_d   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_col <= col;
        s1_row <= row;
        data_d <= data;
        if (col == COL_W'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == ROW_W'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN_TAPS; i++) taps[i] <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= s1_valid && (s1_row >= ROW_W'(2)) && (s1_col >= COL_W'(2));
      frame_done <= s1_valid && (s1_row == ROW_W'(HEIGHT - 1)) && (s1_col == COL_W'(WIDTH - 1));
      if (s1_valid) begin
        taps[P00] <= taps[P01];
        taps[P01] <= taps[P02];
        taps[P02] <= lb1_q;
        taps[P10] <= taps[P11];
        taps[P11] <= taps[P12];
        taps[P12] <= lb0_q;
        taps[P20] <= taps[P21];
        taps[P21] <= taps[P22];
        taps[P22] <= data_d;
        win_x     <= s1_col - 1'b1;
        win_y     <= s1_row - 1'b1;
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < WIN_TAPS; i++) win[i*DATA_W +: DATA_W] = taps[i];
  end
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - randomized self-checking bench against an image-array reference model
module tb_window_3x3_gen;
  localparam int W = 16, H = 8, DW = 8, CW = 4, RW = 3;
  localparam int NWIN = (W - 2) * (H - 2);

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            valid = 1'b0;
  logic [DW-1:0]   data = '0;
  logic            blanking = 1'b0;
  logic            win_valid, frame_done;
  logic [9*DW-1:0] win;
  logic [CW-1:0]   win_x;
  logic [RW-1:0]   win_y;

  window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .COL_W(CW), .ROW_W(RW)) dut (
    .clock(clock), .reset(reset), .valid(valid), .data(data), .blanking(blanking),
    .win_valid(win_valid), .win(win), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [71:0] pix; int x; int y; } exp_t;
  exp_t    wq[$];
  int      fq[$];
  logic [7:0] img [H][W];
  int mr = 0, mc = 0, cyc = 0;
  int n_checks = 0, n_errors = 0;
  int wcnt = 0, fcnt = 0, first_x = -1, first_y = -1, last_x = -1, last_y = -1;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: whenever a pixel is accepted, the window it completes is read straight out of the image.
  task automatic send(input logic [7:0] d, input bit blank);
    exp_t e;
    @(posedge clock); #1;
    valid = 1'b1; blanking = blank; data = d;
    if (!blank) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e.pix = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) e.pix = {e.pix[63:0], img[mr-2+r][mc-2+c]};
        e.due = cyc + 2; e.x = mc - 1; e.y = mr - 1;
        wq.push_back(e);
      end
      if (mr == H - 1 && mc == W - 1) fq.push_back(cyc + 2);
      mc++;
      if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      valid = 1'b0; blanking = 1'b0; data = 8'($urandom);
    end
  endtask

  // mode: 0 ramp, 1 inverted ramp, 2 random; gap: 0 none, 1 every other cycle, 2 random
  task automatic send_frame(input int mode, input int gap, input int burst_row);
    logic [7:0] d;
    wcnt = 0; fcnt = 0; first_x = -1; first_y = -1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        d = 8'((r * W + c) % 256);
        if (mode == 1) d = ~d;
        if (mode == 2) d = 8'($urandom);
        send(d, 1'b0);
        if (gap == 1) idle(1);
        if (gap == 2) idle($urandom_range(0, 2));
        if (r == burst_row && c == 5)
          for (int k = 0; k < 1000; k++) send(8'h02, 1'b1);
      end
      if (gap != 0) begin send(8'h02, 1'b1); send(8'h02, 1'b1); end
    end
    idle(4);
    check("win_count", 72'(wcnt), 72'(NWIN));
    check("frame_done_count", 72'(fcnt), 72'd1);
    check("first_x", 72'(first_x), 72'd1);
    check("first_y", 72'(first_y), 72'd1);
    check("last_x", 72'(last_x), 72'(W - 2));
    check("last_y", 72'(last_y), 72'(H - 2));
  endtask

  always @(negedge clock) begin
    bit ev, fe;
    exp_t e;
    ev = (wq.size() > 0) && (wq[0].due == cyc);
    check("win_valid", 72'(win_valid), 72'(ev));
    if (ev) begin
      e = wq.pop_front();
      check("win", win, e.pix);
      check("win_x", 72'(win_x), 72'(e.x));
      check("win_y", 72'(win_y), 72'(e.y));
      if (first_x < 0) begin first_x = int'(win_x); first_y = int'(win_y); end
      last_x = int'(win_x); last_y = int'(win_y);
      wcnt++;
    end
    fe = (fq.size() > 0) && (fq[0] == cyc);
    check("frame_done", 72'(frame_done), 72'(fe));
    if (fe) begin void'(fq.pop_front()); fcnt++; end
  end

  task automatic check_reset_outputs();
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_win", win, 72'd0);
    check("rst_win_x", 72'(win_x), 72'd0);
    check("rst_win_y", 72'(win_y), 72'd0);
    check("rst_frame_done", 72'(frame_done), 72'd0);
  endtask

  initial begin
    idle(3);
    check_reset_outputs();
    @(posedge clock); #1 reset = 1'b1;
    idle(2);

    send_frame(0, 0, -1);   // back-to-back ramp
    send_frame(0, 1, -1);   // every other cycle, blanking between lines
    send_frame(2, 2, -1);   // random data, random gaps
    send_frame(1, 0, -1);   // inverted ramp right after another frame
    send_frame(2, 0, 3);    // long blanking burst mid-line

    // partial frame, then reset mid-frame
    for (int i = 0; i < (H / 2) * W + W / 2; i++) send(8'($urandom), 1'b0);
    @(posedge clock); #1;
    valid = 1'b0; reset = 1'b0;
    wq.delete(); fq.delete(); mr = 0; mc = 0;
    #1 check_reset_outputs();
    idle(3);
    check_reset_outputs();
    @(posedge clock); #1 reset = 1'b1;
    send_frame(2, 2, -1);
    send_frame(0, 0, -1);

    idle(4);
    check("queue_drained", 72'(wq.size() + fq.size()), 72'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
